// File: rtl/sram_sp_masked_clr_if.sv
// Access bus of the segment-masked single-port SRAM: one access port,
// a clear request and a readiness indication.
interface sram_sp_masked_clr_if #(
  parameter int DATA_W = 148,
  parameter int DEPTH  = 128,
  parameter int SEGS   = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [SEGS-1:0]   RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;
  logic              RW0_rvalid;
  logic              clr_req;
  logic              RW0_ready;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, clr_req,
    input  RW0_rdata, RW0_rvalid, RW0_ready
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, clr_req,
    output RW0_rdata, RW0_rvalid, RW0_ready
  );
endinterface

// File: rtl/sram_sp_masked_clr.sv
// Single-port segment-masked SRAM with optional output register and a
// hardware clear sequencer that sweeps every entry to CLR_VAL.
//
//   state | meaning
//   IDLE  | array accepts accesses (unless a post-reset sweep is pending)
//   CLEAR | sweeping entry cnt_q to CLR_VAL, accesses dropped
module sram_sp_masked_clr #(
  parameter int                      DATA_W     = 148,
  parameter int                      DEPTH      = 128,
  parameter int                      SEGS       = 4,
  parameter int                      OUT_REG    = 0,
  parameter int                      CLR_ON_RST = 1,
  parameter logic [DATA_W/SEGS-1:0]  CLR_VAL    = '0
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_rst_n,
  sram_sp_masked_clr_if.slave   bus
);

  localparam int            SEG_W = DATA_W / SEGS;
  localparam int            AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [AW-1:0]     cnt_q;
  logic              ready_q;
  logic              pend_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_ok;
  logic              acc_ok;
  logic              wr_en;
  logic              rd_en;
  logic              clr_we;
  logic [DATA_W-1:0] s1_data_d;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_vld_q;

  generate
    if ((1 << AW) == DEPTH) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_range
      assign addr_ok = (bus.RW0_addr <= LAST);
    end
  endgenerate

  assign acc_ok = bus.RW0_en & ready_q;
  assign wr_en  = acc_ok & bus.RW0_wmode & addr_ok;
  assign rd_en  = acc_ok & ~bus.RW0_wmode;
  // pend_q makes the first edge after reset release write entry 0, so a
  // post-reset sweep holds ready low for exactly DEPTH cycles.
  assign clr_we = pend_q | (state_q == CLEAR);

  always_ff @(posedge RW0_clk) begin
    if (!RW0_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= (CLR_ON_RST == 0);
      pend_q  <= (CLR_ON_RST != 0);
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            pend_q  <= 1'b0;
          end else if (bus.clr_req) begin
            state_q <= CLEAR;
            ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (RW0_rst_n) begin
      if (clr_we) begin
        mem[cnt_q] <= {SEGS{CLR_VAL}};
      end else if (wr_en) begin
        for (int i = 0; i < SEGS; i++) begin
          if (bus.RW0_wmask[i]) begin
            mem[bus.RW0_addr][i*SEG_W +: SEG_W] <= bus.RW0_wdata[i*SEG_W +: SEG_W];
          end
        end
      end
    end
  end

  // Out-of-range reads return zero rather than whatever the index aliases to.
  assign s1_data_d = addr_ok ? mem[bus.RW0_addr] : '0;

  always_ff @(posedge RW0_clk) begin
    if (!RW0_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= s1_data_d;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s2_data_q;
      logic              s2_vld_q;

      always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
          s2_vld_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign bus.RW0_rdata  = s2_data_q;
      assign bus.RW0_rvalid = s2_vld_q;
    end else begin : g_noreg
      assign bus.RW0_rdata  = s1_data_q;
      assign bus.RW0_rvalid = s1_vld_q;
    end
  endgenerate

  assign bus.RW0_ready = ready_q;

endmodule

// File: tb/tb_sram_sp_masked_clr.sv
// Scoreboard bench: instance A (128 deep, latency 1) and instance B
// (100 deep, latency 2, nonzero clear value) driven with directed vectors.
module tb_sram_sp_masked_clr;

  localparam int DW = 148;
  localparam int SW = 37;

  localparam logic [SW-1:0] CLRB  = 37'h0A5A5A5A5;
  localparam logic [SW-1:0] ONES  = {SW{1'b1}};
  localparam logic [SW-1:0] ZERO  = {SW{1'b0}};
  localparam logic [DW-1:0] ALL1  = {DW{1'b1}};
  localparam logic [DW-1:0] NONE  = {DW{1'b0}};
  localparam logic [DW-1:0] MSK   = {ONES, ZERO, ONES, ZERO};
  localparam logic [DW-1:0] SEG3  = {ONES, ZERO, ZERO, ZERO};
  localparam logic [DW-1:0] CLRB4 = {CLRB, CLRB, CLRB, CLRB};
  localparam logic [DW-1:0] P1    = {4{37'h123456789}};
  localparam logic [DW-1:0] P2    = {4{37'h10F0F0F0F}};
  localparam logic [DW-1:0] P3    = {4{37'h0F0F0F0F0}};
  localparam logic [DW-1:0] PA    = {4{37'h1DEADBEEF}};

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_sp_masked_clr_if #(.DATA_W(DW), .DEPTH(128), .SEGS(4)) ifa ();
  sram_sp_masked_clr_if #(.DATA_W(DW), .DEPTH(100), .SEGS(4)) ifb ();

  sram_sp_masked_clr #(
    .DATA_W(DW), .DEPTH(128), .SEGS(4), .OUT_REG(0), .CLR_ON_RST(1), .CLR_VAL(ZERO)
  ) dut_a (
    .RW0_clk   (clk),
    .RW0_rst_n (rst_a),
    .bus       (ifa)
  );

  sram_sp_masked_clr #(
    .DATA_W(DW), .DEPTH(100), .SEGS(4), .OUT_REG(1), .CLR_ON_RST(1), .CLR_VAL(CLRB)
  ) dut_b (
    .RW0_clk   (clk),
    .RW0_rst_n (rst_b),
    .bus       (ifb)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   low_a = 0;
  int   low_b = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every rvalid and checks data and arrival cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!ifa.RW0_ready) low_a++;
    if (!ifb.RW0_ready) low_b++;
    if (ifa.RW0_rvalid) begin
      if (qa.size() == 0) begin
        check("a_spurious_rvalid", DW'(ifa.RW0_rvalid), NONE);
      end else begin
        e = qa.pop_front();
        check("a_rdata", ifa.RW0_rdata, e.d);
        check("a_latency", DW'(cyc), DW'(e.due));
      end
    end
    if (ifb.RW0_rvalid) begin
      if (qb.size() == 0) begin
        check("b_spurious_rvalid", DW'(ifb.RW0_rvalid), NONE);
      end else begin
        e = qb.pop_front();
        check("b_rdata", ifb.RW0_rdata, e.d);
        check("b_latency", DW'(cyc), DW'(e.due));
      end
    end
  end

  task automatic acc(input int d, input bit we, input int addr, input logic [3:0] m,
                     input logic [DW-1:0] wd, input bit push, input logic [DW-1:0] ex);
    @(posedge clk);
    #1;
    if (d == 0) begin
      ifa.RW0_en    = 1'b1;
      ifa.RW0_wmode = we;
      ifa.RW0_addr  = 7'(addr);
      ifa.RW0_wmask = m;
      ifa.RW0_wdata = wd;
      if (push) qa.push_back('{d: ex, due: cyc + 1});
    end else begin
      ifb.RW0_en    = 1'b1;
      ifb.RW0_wmode = we;
      ifb.RW0_addr  = 7'(addr);
      ifb.RW0_wmask = m;
      ifb.RW0_wdata = wd;
      if (push) qb.push_back('{d: ex, due: cyc + 2});
    end
  endtask

  task automatic wr(input int d, input int addr, input logic [3:0] m, input logic [DW-1:0] wd);
    acc(d, 1'b1, addr, m, wd, 1'b0, NONE);
  endtask

  task automatic rd(input int d, input int addr, input logic [DW-1:0] ex);
    acc(d, 1'b0, addr, 4'h0, NONE, 1'b1, ex);
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ifa.RW0_en = 1'b0;  ifa.clr_req = 1'b0;
      ifb.RW0_en = 1'b0;  ifb.clr_req = 1'b0;
    end
  endtask

  task automatic wait_ready(input int d, input string nm);
    int n = 0;
    logic r;
    r = (d == 0) ? ifa.RW0_ready : ifb.RW0_ready;
    while (r !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      r = (d == 0) ? ifa.RW0_ready : ifb.RW0_ready;
    end
    if (n >= 1000) check(nm, DW'(r), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: stuck at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.RW0_en = 1'b0; ifa.RW0_wmode = 1'b0; ifa.RW0_addr = '0;
    ifa.RW0_wmask = '0; ifa.RW0_wdata = '0; ifa.clr_req = 1'b0;
    ifb.RW0_en = 1'b0; ifb.RW0_wmode = 1'b0; ifb.RW0_addr = '0;
    ifb.RW0_wmask = '0; ifb.RW0_wdata = '0; ifb.clr_req = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_ready",  DW'(ifa.RW0_ready),  NONE);
    check("a_rst_rvalid", DW'(ifa.RW0_rvalid), NONE);
    check("a_rst_rdata",  ifa.RW0_rdata,       NONE);
    check("b_rst_ready",  DW'(ifb.RW0_ready),  NONE);
    check("b_rst_rvalid", DW'(ifb.RW0_rvalid), NONE);
    check("b_rst_rdata",  ifb.RW0_rdata,       NONE);

    // Post-reset sweeps: ready low for exactly DEPTH cycles.
    @(posedge clk);
    #1;
    rst_a = 1'b1; rst_b = 1'b1; low_a = 0; low_b = 0;
    wait_ready(0, "a_init_sweep_timeout");
    check("a_init_sweep_len", DW'(low_a), DW'(128));
    wait_ready(1, "b_init_sweep_timeout");
    check("b_init_sweep_len", DW'(low_b), DW'(100));

    for (int i = 0; i < 128; i++) rd(0, i, NONE);
    quiet(1);

    // Segment masks, including wmask = 0 and read right after write.
    wr(0, 5, 4'hF, ALL1);
    wr(0, 5, 4'h5, NONE);
    rd(0, 5, MSK);
    wr(0, 5, 4'h0, ALL1);
    rd(0, 5, MSK);
    wr(0, 6, 4'h8, ALL1);
    rd(0, 6, SEG3);
    quiet(1);

    // Latency-2 streaming and hold of the last result.
    wr(1, 1, 4'hF, P1);
    wr(1, 2, 4'hF, P2);
    wr(1, 3, 4'hF, P3);
    rd(1, 1, P1);
    rd(1, 2, P2);
    rd(1, 3, P3);
    quiet(1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("b_hold_rdata",  ifb.RW0_rdata,       P3);
      check("b_hold_rvalid", DW'(ifb.RW0_rvalid), NONE);
    end

    // Non-power-of-two depth: out-of-range write ignored, read returns 0.
    wr(1, 99, 4'hF, ALL1);
    wr(1, 120, 4'hF, ALL1);
    rd(1, 120, NONE);
    rd(1, 20, CLRB4);
    rd(1, 99, ALL1);
    rd(1, 0, CLRB4);
    quiet(1);

    // clr_req with a read in flight, then accesses during the sweep are dropped.
    wr(0, 7, 4'hF, PA);
    rd(0, 7, PA);
    ifa.clr_req = 1'b1;
    low_a = 0;
    wr(0, 7, 4'hF, ALL1);
    ifa.clr_req = 1'b0;
    acc(0, 1'b0, 7, 4'h0, NONE, 1'b0, NONE);
    wr(0, 127, 4'hF, ALL1);
    quiet(1);
    wait_ready(0, "a_req_sweep_timeout");
    check("a_req_sweep_len", DW'(low_a), DW'(128));
    rd(0, 7, NONE);
    rd(0, 127, NONE);
    wr(0, 100, 4'hF, PA);
    quiet(1);

    // Reset at sweep cycle 40 aborts; release starts a fresh full sweep that
    // ignores a clr_req at its cycle 10.
    @(posedge clk);
    #1;
    ifa.clr_req = 1'b1;
    quiet(1);
    repeat (40) @(posedge clk);
    #1;
    rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    low_a = 0;
    repeat (10) @(posedge clk);
    #1;
    ifa.clr_req = 1'b1;
    quiet(1);
    wait_ready(0, "a_rst_sweep_timeout");
    check("a_rst_sweep_len", DW'(low_a), DW'(128));
    rd(0, 100, NONE);
    rd(0, 5, NONE);
    quiet(1);

    repeat (5) @(negedge clk);
    check("a_queue_drained", DW'(qa.size()), NONE);
    check("b_queue_drained", DW'(qb.size()), NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
